// File: rtl/tms34020_mm_seq_if.sv
// Register-file and memory-bus ports owned by the multi-register move sequencer.
// master = sequencer side, slave = register file / memory side.
interface tms34020_mm_seq_if;
    logic [4:0]  RA_A;
    logic [31:0] RA_Q;
    logic [4:0]  RB_A;
    logic [31:0] RB_Q;
    logic [4:0]  WA_A;
    logic [31:0] WA_D;
    logic        WA_WE;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK;

    modport master (
        output RA_A, RB_A, WA_A, WA_D, WA_WE,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  RA_Q, RB_Q, MEM_RDATA, MEM_ACK
    );

    modport slave (
        input  RA_A, RB_A, WA_A, WA_D, WA_WE,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output RA_Q, RB_Q, MEM_RDATA, MEM_ACK
    );
endinterface

// File: rtl/tms34020_mm_seq.sv
// TMS34020 MMTM/MMFM sequencer: walks a 16-bit register mask, moving one
// register per memory transfer, then writes the updated pointer back.
module tms34020_mm_seq #(
    parameter int unsigned STEP = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CE,
    input  logic                     START,
    input  logic                     DIR,
    input  logic                     RFILE,
    input  logic [3:0]               PTR_A,
    input  logic [15:0]              MASK,
    output logic                     BUSY,
    output logic                     DONE,
    tms34020_mm_seq_if.master        bus
);

    localparam logic [31:0] STEP_V = 32'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_PTR, S_XFER, S_FINAL} state_t;

    state_t      state, state_n;
    logic [31:0] ptr_r;
    logic [15:0] rem_r;
    logic [3:0]  cur_r;
    logic        dir_r;
    logic        rfile_r;
    logic [3:0]  pa_r;
    logic [15:0] rem_clr;

    function automatic logic [3:0] hi_bit(input logic [15:0] m);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++)
            if (m[i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic [3:0] lo_bit(input logic [15:0] m);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 16; i > 0; i--)
            if (m[i-1]) r = 4'(i - 1);
        return r;
    endfunction

    // Stores walk the list top-down (pre-decrement), loads bottom-up (post-increment).
    function automatic logic [3:0] pick(input logic d, input logic [15:0] m);
        return d ? lo_bit(m) : hi_bit(m);
    endfunction

    assign rem_clr = rem_r & ~(16'd1 << cur_r);

    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_IDLE;
        else if (CE)
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (START) state_n = S_PTR;
            S_PTR:   state_n = (rem_r == '0) ? S_FINAL : S_XFER;
            S_XFER:  if (bus.MEM_ACK) state_n = (rem_clr == '0) ? S_FINAL : S_XFER;
            S_FINAL: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_r   <= '0;
            rem_r   <= '0;
            cur_r   <= '0;
            dir_r   <= 1'b0;
            rfile_r <= 1'b0;
            pa_r    <= '0;
        end else if (CE) begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        dir_r   <= DIR;
                        rfile_r <= RFILE;
                        pa_r    <= PTR_A;
                        rem_r   <= MASK;
                    end
                end
                S_PTR: begin
                    ptr_r <= bus.RA_Q;
                    cur_r <= pick(dir_r, rem_r);
                end
                S_XFER: begin
                    if (bus.MEM_ACK) begin
                        rem_r <= rem_clr;
                        cur_r <= pick(dir_r, rem_clr);
                        ptr_r <= dir_r ? ptr_r + STEP_V : ptr_r - STEP_V;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        BUSY          = (state != S_IDLE);
        DONE          = 1'b0;
        bus.RA_A      = {rfile_r, pa_r};
        bus.RB_A      = {rfile_r, cur_r};
        bus.WA_A      = '0;
        bus.WA_D      = '0;
        bus.WA_WE     = 1'b0;
        bus.MEM_REQ   = 1'b0;
        bus.MEM_WE    = 1'b0;
        bus.MEM_ADDR  = '0;
        bus.MEM_WDATA = '0;
        case (state)
            S_XFER: begin
                bus.MEM_REQ = 1'b1;
                if (dir_r) begin
                    bus.MEM_ADDR = ptr_r;
                    if (bus.MEM_ACK) begin
                        bus.WA_WE = 1'b1;
                        bus.WA_A  = {rfile_r, cur_r};
                        bus.WA_D  = bus.MEM_RDATA;
                    end
                end else begin
                    bus.MEM_WE    = 1'b1;
                    bus.MEM_ADDR  = ptr_r - STEP_V;
                    bus.MEM_WDATA = bus.RB_Q;
                end
            end
            S_FINAL: begin
                DONE      = 1'b1;
                bus.WA_WE = 1'b1;
                bus.WA_A  = {rfile_r, pa_r};
                bus.WA_D  = ptr_r;
            end
            default: ;
        endcase
    end

endmodule
